// File: rtl/qeciphy_tx_buffer_if.sv
// qeciphy_tx_buffer_if: AXI-Stream data/valid/ready bundle used on both sides of the TX buffer.
interface qeciphy_tx_buffer_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    modport master(output tdata, output tvalid, input tready);
    modport slave(input tdata, input tvalid, output tready);
endinterface

// File: rtl/qeciphy_tx_buffer.sv
// qeciphy_tx_buffer: elastic AXIS buffer ahead of QECIPHY TX; releases words only while the link is ready
// and optionally discards (and counts) stale words when the link drops.
module qeciphy_tx_buffer #(
    parameter int DATA_WIDTH         = 64,
    parameter int DEPTH              = 16,
    parameter int FLUSH_ON_LINK_DOWN = 1
) (
    input  logic                     ACLK,
    input  logic                     ARSTn,
    qeciphy_tx_buffer_if.slave       s_axis,
    qeciphy_tx_buffer_if.master      m_axis,
    input  logic                     link_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [15:0]              flush_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] ST_DOWN = 2'd0, ST_ACTIVE = 2'd1, ST_FLUSH = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q;
    logic [15:0]           flush_cnt_q, flush_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  full, empty, wr_en, rd_en;
    logic [16:0]           flush_sum;

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Ready is gated by reset so the source sees no acceptance while held in reset.
    assign s_axis.tready = ARSTn && !full && state_q != ST_FLUSH;
    assign m_axis.tvalid = !empty && state_q == ST_ACTIVE;
    assign m_axis.tdata  = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_en         = s_axis.tvalid && s_axis.tready;
    assign rd_en         = m_axis.tvalid && m_axis.tready;
    assign flush_sum     = {1'b0, flush_cnt_q} + 17'(level_q);
    assign level_o       = level_q;
    assign flush_cnt_o   = flush_cnt_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d    = state_q == ST_FLUSH ? wr_ptr_q : rd_ptr_q + (AW+1)'(rd_en);
        flush_cnt_d = state_q != ST_FLUSH ? flush_cnt_q : flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        state_d     = state_q == ST_FLUSH ? ST_DOWN :
                      state_q == ST_DOWN  ? (link_ready_i ? ST_ACTIVE : ST_DOWN) :
                      link_ready_i        ? ST_ACTIVE :
                      FLUSH_ON_LINK_DOWN != 0 ? ST_FLUSH : ST_DOWN;
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q     <= ST_DOWN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= wr_ptr_d - rd_ptr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_axis.tdata;
    end
endmodule

// File: tb/tb_qeciphy_tx_buffer.sv
// tb_qeciphy_tx_buffer: drives a flushing and a retaining buffer with identical stimulus and
// scoreboards every cycle's outputs against a queue-based model of the link/buffer behaviour.
module tb_qeciphy_tx_buffer;
    localparam int DW = 64, DEPTH = 16;

    typedef struct packed {
        logic        sr;
        logic        mv;
        logic [63:0] md;
        logic [4:0]  lvl;
        logic [15:0] fc;
    } rec_t;

    logic        clk = 0, arstn = 0, sv = 0, mr = 0, link = 0;
    logic [63:0] sd = '0;
    logic        sr_o [2];
    logic        mv_o [2];
    logic [63:0] md_o [2];
    logic [4:0]  lvl_o [2];
    logic [15:0] fc_o [2];

    int          phase [2];
    int          mfc [2];
    logic [63:0] mq [2][$];
    rec_t        expq [2][$];
    int          n_acc = 0, checks = 0, passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        qeciphy_tx_buffer_if #(.DATA_WIDTH(DW)) s_if ();
        qeciphy_tx_buffer_if #(.DATA_WIDTH(DW)) m_if ();
        assign s_if.tdata  = sd;
        assign s_if.tvalid = sv;
        assign m_if.tready = mr;
        assign sr_o[g]     = s_if.tready;
        assign mv_o[g]     = m_if.tvalid;
        assign md_o[g]     = m_if.tdata;
        qeciphy_tx_buffer #(
            .DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUSH_ON_LINK_DOWN(g == 0 ? 1 : 0)
        ) u_dut (
            .ACLK(clk), .ARSTn(arstn), .s_axis(s_if), .m_axis(m_if),
            .link_ready_i(link), .level_o(lvl_o[g]), .flush_cnt_o(fc_o[g])
        );
    end

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    endtask

    // Model phases: 0 link down, 1 streaming, 2 one-cycle discard after link loss.
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            rec_t r;
            int n;
            if (!arstn) begin
                mq[d].delete();
                phase[d] = 0;
                mfc[d] = 0;
            end
            n = mq[d].size();
            r.sr  = arstn && phase[d] != 2 && n < DEPTH;
            r.mv  = arstn && phase[d] == 1 && n > 0;
            r.md  = r.mv ? mq[d][0] : '0;
            r.lvl = 5'(n);
            r.fc  = 16'(mfc[d]);
            expq[d].push_back(r);
            if (arstn) begin
                if (phase[d] == 2) begin
                    mfc[d] = (mfc[d] + n > 65535) ? 65535 : mfc[d] + n;
                    mq[d].delete();
                    phase[d] = 0;
                end else begin
                    if (sv && r.sr) begin
                        mq[d].push_back(sd);
                        if (d == 0) n_acc++;
                    end
                    if (r.mv && mr) void'(mq[d].pop_front());
                    phase[d] = phase[d] == 0 ? (link ? 1 : 0) : link ? 1 : (d == 0 ? 2 : 0);
                end
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [63:0] dt, input logic r, input logic l, input logic rn = 1'b1);
        @(negedge clk);
        sv = v;
        sd = dt;
        mr = r;
        link = l;
        arstn = rn;
        step();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                rec_t e;
                if (expq[d].size() > 0) begin
                    e = expq[d].pop_front();
                    chk("s_tready", d, 64'(sr_o[d]), 64'(e.sr));
                    chk("m_tvalid", d, 64'(mv_o[d]), 64'(e.mv));
                    chk("level", d, 64'(lvl_o[d]), 64'(e.lvl));
                    chk("flush_cnt", d, 64'(fc_o[d]), 64'(e.fc));
                    if (e.mv) chk("m_tdata", d, md_o[d], e.md);
                end
            end
        end
    end

    initial begin
        repeat (3) cyc(0, '0, 0, 0, 0);
        for (int i = 0; i < 17; i++) cyc(1, 64'(i), 0, 0);
        repeat (20) cyc(0, '0, 1, 1);
        cyc(1, 64'hDEADBEEF_00000001, 1, 1);
        for (int i = 0; i < 10; i++) cyc(1, 64'hDEADBEEF_00000100 + 64'(i), 1, 1);
        repeat (3) cyc(0, '0, 1, 1);
        n_acc = 0;
        for (int i = 0; i < 20000 && n_acc < 2048; i++)
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
        chk("random_budget", 0, 64'(n_acc >= 2048), 64'd1);
        repeat (40) cyc(0, '0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 64'h5500 + 64'(i), 0, 1);
        repeat (3) cyc(0, '0, 0, 0);
        repeat (12) cyc(0, '0, 1, 1);
        for (int i = 0; i < 9; i++) cyc(1, 64'h6600 + 64'(i), 0, 1);
        cyc(1, 64'h6609, 1, 1);
        repeat (2) cyc(1, 64'h660A, 1, 1, 0);
        repeat (200) cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
        repeat (600) cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0),
                         1'($urandom_range(0, 9) != 0));
        repeat (30) cyc(0, '0, 1, 1);
        @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
